// File: rtl/mmm_sequencer.sv
// mmm_sequencer: sequences the N x N x N multiply-accumulate walk of the MEM-stage MMM unit.
// Optional feature macro: MMM_SEQ_PERF_CNT_EN (busy-cycle counter on perf_cycles).
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   start_mmm, wait_mmm_finish   requests from the MEM stage
//   cfg_data                     rs2 value accompanying start_mmm, [7:0] = N
//   a_rd_addr, b_rd_addr, rd_en  A/B scratchpad reads (1-cycle latency)
//   mac_en, mac_first            MAC operand valid / load-instead-of-accumulate
//   c_wr_addr, c_wr_en           C writeback
//   busy, done, stall            status, completion pulse, combinational stall request
//   perf_cycles                  busy cycles of the most recent operation
module mmm_sequencer #(
  parameter int DIM_MAX = 8,
  localparam int ADDR_W = $clog2(DIM_MAX * DIM_MAX)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_mmm,
  input  logic              wait_mmm_finish,
  input  logic [31:0]       cfg_data,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] b_rd_addr,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_first,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic              c_wr_en,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [31:0]       perf_cycles
);
  localparam int LW = $clog2(DIM_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t          state;
  logic [LW-1:0]   i, j, k;
  logic [LW:0]     n, n_req;
  logic            last_i, last_j, last_k, drain_last, wr_s1;
  logic [ADDR_W-1:0] c_addr_s1;
  logic            unused_cfg;
  assign unused_cfg = ^cfg_data[31:8];
  assign n_req  = (cfg_data[7:0] > 8'(DIM_MAX)) ? (LW+1)'(DIM_MAX) : cfg_data[LW:0];
  assign last_i = {1'b0, i} == n - 1'b1;
  assign last_j = {1'b0, j} == n - 1'b1;
  assign last_k = {1'b0, k} == n - 1'b1;
  // DIM_MAX is a power of two, so row*DIM_MAX+col is plain concatenation
  assign a_rd_addr = {i, k};
  assign b_rd_addr = {k, j};
  assign rd_en     = state == ISSUE;
  assign stall     = busy & (wait_mmm_finish | start_mmm);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      n          <= '0;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      drain_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_mmm) begin
          n     <= n_req;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          busy  <= 1'b1;
          done  <= n_req == '0;
          state <= (n_req == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          k          <= last_k ? '0 : k + 1'b1;
          j          <= last_k ? (last_j ? '0 : j + 1'b1) : j;
          i          <= (last_k && last_j) ? (last_i ? '0 : i + 1'b1) : i;
          drain_last <= 1'b0;
          state      <= (last_k && last_j && last_i) ? DRAIN : ISSUE;
        end
        // two cycles let the read and MAC stages empty before completion
        DRAIN: begin
          drain_last <= 1'b1;
          done       <= drain_last;
          state      <= drain_last ? DONE : DRAIN;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // read data arrives one cycle after issue, the MAC result one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      wr_s1     <= 1'b0;
      c_addr_s1 <= '0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
    end else begin
      mac_en    <= rd_en;
      mac_first <= rd_en & (k == '0);
      wr_s1     <= rd_en & last_k;
      c_addr_s1 <= {i, j};
      c_wr_en   <= wr_s1;
      c_wr_addr <= c_addr_s1;
    end
  end
`ifdef MMM_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_cycles <= '0;
    else if (state == IDLE && start_mmm) perf_cycles <= '0;
    else if (busy) perf_cycles <= perf_cycles + 1'b1;
  end
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: doc/mmm_sequencer.md
Name: mmm_sequencer

Overview:
- Sequences the matrix-matrix-multiply (MMM) unit in the MEM stage.
- A `start_mmm` instruction launches an N×N×N multiply-accumulate walk over the A/B scratchpads. The block drives read addresses, MAC controls and C writebacks.
- Raises a pipeline stall while `wait_mmm_finish` (or a new `start_mmm`) is presented during an operation.

Parameters:
- DIM_MAX, 8: maximum matrix dimension; must be a power of two, ≥2.
- ADDR_W, $clog2(DIM_MAX*DIM_MAX): scratchpad address width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start_mmm  in  1  start request from MEM stage
- wait_mmm_finish  in  1  wait request from MEM stage
- cfg_data  in  32  rs2 value accompanying start_mmm; [7:0] = N
- a_rd_addr  out  ADDR_W  A scratchpad read address (row-major, i*DIM_MAX+k)
- b_rd_addr  out  ADDR_W  B scratchpad read address (k*DIM_MAX+j)
- rd_en  out  1  A/B read strobe (1-cycle read latency)
- mac_en  out  1  MAC operand valid
- mac_first  out  1  with mac_en: load product instead of accumulate
- c_wr_addr  out  ADDR_W  C write address (i*DIM_MAX+j)
- c_wr_en  out  1  write MAC result to C
- busy  out  1  operation in progress
- done  out  1  1-cycle completion pulse
- stall  out  1  pipeline stall request (combinational)
- perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, reset_n=0): state IDLE, all counters 0, all outputs 0. Reset mid-operation aborts immediately; no further C writes.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_mmm=1 latches N = cfg_data[7:0].
  - N>DIM_MAX clamps to DIM_MAX.
  - N==0: go to DONE directly (done pulses next cycle, no reads/writes).
  - Otherwise clear i/j/k and go to ISSUE.
- ISSUE:
  - Each cycle: rd_en=1, addresses from current (i,k),(k,j).
  - k increments; on k=N-1 wrap k to 0 and increment j; on j=N-1 wrap j and increment i.
  - After the read with i=j=k=N-1, go to DRAIN.
  - Exactly N³ ISSUE cycles, no bubbles.
- Pipeline, registered:
  - mac_en = rd_en delayed 1.
  - mac_first = (k==0 at issue) delayed 1.
  - c_wr_en = (k==N-1 at issue) delayed 2.
  - c_wr_addr = (i,j) of that issue delayed 2.
- DRAIN: 2 cycles, flushing the pipeline; the last c_wr_en occurs in the 2nd DRAIN cycle. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE), registered with state. For N≥1: N³+3 cycles.
- stall = (state != IDLE) & (wait_mmm_finish | start_mmm).
  - start_mmm while busy is held off via stall and accepted in the first IDLE cycle.
  - wait_mmm_finish in IDLE: no stall.
- Simultaneous start_mmm and wait_mmm_finish in IDLE: start wins; stall stays 0 that cycle.
- cfg_data bits [31:8] ignored.
- Arithmetic: addresses computed as unsigned i*DIM_MAX+k with shift (DIM_MAX power of two); no multiplier inferred.

Optional Feature:
- Macro: MMM_SEQ_PERF_CNT_EN.
- Defined:
  - perf_cycles counts cycles with busy=1 for the most recent operation.
  - Cleared on start acceptance; frozen at DONE until the next start.
  - Reset value 0.
- Undefined: perf_cycles tied to 0; no counter flops.

Test Plan:
- Reset then start_mmm=1, cfg_data=2 -> rd_en high 8 consecutive cycles, with:
  - a_rd_addr sequence 0,1,0,1,8,9,8,9;
  - b_rd_addr sequence 0,8,1,9,0,8,1,9;
  - c_wr_en 4 pulses at addrs 0,1,8,9;
  - busy 11 cycles; done 1 pulse.
- cfg_data=1 -> one read at addr 0/0, mac_first with mac_en, one C write at 0, busy 4 cycles.
- cfg_data=0 -> no rd_en/c_wr_en, busy 1 cycle, done pulse; cfg_data=20 -> clamped to 8, 512 ISSUE cycles.
- wait_mmm_finish=1 held from mid-run -> stall=1 until the cycle busy drops, then 0; wait_mmm_finish in IDLE -> stall=0.
- Second start_mmm during run -> stall=1, accepted on first IDLE cycle; perf_cycles=11 after N=2 (MMM_SEQ_PERF_CNT_EN defined), 0 if undefined.
- reset_n low mid-ISSUE -> all outputs 0 asynchronously; no c_wr_en after release; new start runs normally.
